// File: rtl/puf_response_collector.sv
// Sequences PUF challenges: clears and enables the counter stage, waits for a measurement window,
// compares the two counts and packs one response bit per challenge into a ready/valid word.
module puf_response_collector #(
  parameter int unsigned CNT_W        = 22,
  parameter int unsigned RESP_BITS    = 16,
  parameter int unsigned SEL_W        = 4,
  parameter int unsigned CLEAR_CYCLES = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 finished,
  input  logic [CNT_W-1:0]     count_a,
  input  logic [CNT_W-1:0]     count_b,
  output logic                 cnt_clear,
  output logic                 cnt_enable,
  output logic [SEL_W-1:0]     mux_sel,
  output logic [RESP_BITS-1:0] response,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic                 tie_flag,
  output logic                 busy
);

  localparam int unsigned IDX_W = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
  localparam int unsigned CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RESP_BITS - 1);
  localparam logic [CLR_W-1:0] LAST_CLR = CLR_W'(CLEAR_CYCLES - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CLEAR   = 3'd1;
  localparam logic [2:0] S_RUN     = 3'd2;
  localparam logic [2:0] S_CAPTURE = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]           state_q,      state_d;
  logic [CLR_W-1:0]     clr_cnt_q,    clr_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q,    bit_idx_d;
  logic [SEL_W-1:0]     mux_sel_q,    mux_sel_d;
  logic [RESP_BITS-1:0] response_q,   response_d;
  logic                 tie_flag_q,   tie_flag_d;
  logic                 resp_valid_q, resp_valid_d;
  logic                 cnt_clear_q,  cnt_clear_d;
  logic                 cnt_enable_q, cnt_enable_d;
  logic                 busy_q,       busy_d;

  always_comb begin
    state_d    = state_q;
    clr_cnt_d  = clr_cnt_q;
    bit_idx_d  = bit_idx_q;
    mux_sel_d  = mux_sel_q;
    response_d = response_q;
    tie_flag_d = tie_flag_q;

    // abort outranks everything, including a start in the same IDLE cycle
    if (abort) begin
      state_d   = S_IDLE;
      clr_cnt_d = '0;
      bit_idx_d = '0;
      mux_sel_d = '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d    = S_CLEAR;
            clr_cnt_d  = '0;
            bit_idx_d  = '0;
            mux_sel_d  = '0;
            response_d = '0;
            tie_flag_d = 1'b0;
          end
        end
        S_CLEAR: begin
          if (clr_cnt_q == LAST_CLR) begin
            clr_cnt_d = '0;
            state_d   = S_RUN;
          end else begin
            clr_cnt_d = clr_cnt_q + CLR_W'(1);
          end
        end
        S_RUN: begin
          if (finished) state_d = S_CAPTURE;
        end
        S_CAPTURE: begin
          response_d[bit_idx_q] = (count_a > count_b);
          if (count_a == count_b) tie_flag_d = 1'b1;
          if (bit_idx_q == LAST_IDX) begin
            state_d = S_DONE;
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            mux_sel_d = mux_sel_q + SEL_W'(1);
            state_d   = S_CLEAR;
          end
        end
        S_DONE: begin
          if (resp_valid_q && resp_ready) state_d = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end

    // outputs are registered images of the next state
    cnt_clear_d  = (state_d == S_IDLE) || (state_d == S_CLEAR) || (state_d == S_DONE);
    cnt_enable_d = (state_d == S_RUN);
    resp_valid_d = (state_d == S_DONE);
    busy_d       = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      clr_cnt_q    <= '0;
      bit_idx_q    <= '0;
      mux_sel_q    <= '0;
      response_q   <= '0;
      tie_flag_q   <= 1'b0;
      resp_valid_q <= 1'b0;
      cnt_clear_q  <= 1'b1;
      cnt_enable_q <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      clr_cnt_q    <= clr_cnt_d;
      bit_idx_q    <= bit_idx_d;
      mux_sel_q    <= mux_sel_d;
      response_q   <= response_d;
      tie_flag_q   <= tie_flag_d;
      resp_valid_q <= resp_valid_d;
      cnt_clear_q  <= cnt_clear_d;
      cnt_enable_q <= cnt_enable_d;
      busy_q       <= busy_d;
    end
  end

  assign cnt_clear  = cnt_clear_q;
  assign cnt_enable = cnt_enable_q;
  assign mux_sel    = mux_sel_q;
  assign response   = response_q;
  assign resp_valid = resp_valid_q;
  assign tie_flag   = tie_flag_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_puf_response_collector.sv
// Scoreboard bench: a behavioural counter-stage responder feeds counts per challenge,
// expected words are queued at start and checked by an independent monitor on each transfer.
`timescale 1ns/1ps
module tb_puf_response_collector;
  localparam int CNT_W        = 22;
  localparam int RESP_BITS    = 16;
  localparam int SEL_W        = 4;
  localparam int CLEAR_CYCLES = 2;

  logic                 clk = 1'b0;
  logic                 reset, start, abort, finished, resp_ready;
  logic [CNT_W-1:0]     count_a, count_b;
  logic                 cnt_clear, cnt_enable, resp_valid, tie_flag, busy;
  logic [SEL_W-1:0]     mux_sel;
  logic [RESP_BITS-1:0] response;

  always #5 clk = ~clk;

  puf_response_collector #(
    .CNT_W(CNT_W), .RESP_BITS(RESP_BITS), .SEL_W(SEL_W), .CLEAR_CYCLES(CLEAR_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .finished(finished),
    .count_a(count_a), .count_b(count_b), .cnt_clear(cnt_clear), .cnt_enable(cnt_enable),
    .mux_sel(mux_sel), .response(response), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .tie_flag(tie_flag), .busy(busy)
  );

  typedef struct packed {
    logic [RESP_BITS-1:0] word;
    logic                 tie;
  } exp_t;

  int   tests = 0;
  int   fails = 0;
  int   fin_delay = 10;
  bit   hold_fin = 1'b0;
  int   rst_events = 0;
  exp_t exp_q[$];
  logic [CNT_W-1:0] ta [RESP_BITS];
  logic [CNT_W-1:0] tbv[RESP_BITS];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endfunction

  // Reference: challenge i answers 1 iff A counted strictly more than B; any equality marks a tie.
  function automatic exp_t model();
    exp_t e;
    e.word = '0;
    e.tie  = 1'b0;
    for (int i = 0; i < RESP_BITS; i++) begin
      if (ta[i] > tbv[i])  e.word[i] = 1'b1;
      if (ta[i] == tbv[i]) e.tie     = 1'b1;
    end
    return e;
  endfunction

  task automatic fill(input int mode);
    logic [CNT_W-1:0] lo, hi;
    for (int i = 0; i < RESP_BITS; i++) begin
      lo = CNT_W'($urandom_range(0, 4000000));
      hi = lo + CNT_W'($urandom_range(1, 1000));
      case (mode)
        0: begin ta[i] = CNT_W'(100); tbv[i] = CNT_W'(50); end
        1, 2: begin
          ta[i]  = (i % 2 == 0) ? hi : lo;
          tbv[i] = (i % 2 == 0) ? lo : hi;
        end
        default: begin
          ta[i]  = CNT_W'($urandom);
          tbv[i] = ($urandom_range(0, 3) == 0) ? ta[i] : CNT_W'($urandom);
        end
      endcase
    end
    if (mode == 2) begin
      ta[3]  = 22'h200000;
      tbv[3] = 22'h200000;
    end
  endtask

  // Counter-stage stand-in: counts RUN cycles, raises finished, presents counts for the selected pair.
  initial begin
    int run_cyc = 0;
    forever begin
      @(posedge clk);
      #1;
      if (cnt_enable) begin
        run_cyc++;
        if (hold_fin || run_cyc >= fin_delay) finished = 1'b1;
      end else if (cnt_clear) begin
        run_cyc = 0;
        if (!hold_fin) finished = 1'b0;
      end
      count_a = ta[mux_sel];
      count_b = tbv[mux_sel];
    end
  end

  // Monitor: protocol/sequencing checks and scoreboard comparison on each transfer.
  initial begin
    bit prev_en = 0, prev_valid = 0, prev_ready = 0, prev_abort = 0;
    logic [RESP_BITS-1:0] prev_resp = '0;
    logic [SEL_W-1:0]     run_sel = '0;
    int clr_len = 0, run_idx = 0, seen_rst = 0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset || seen_rst != rst_events) begin
        seen_rst = rst_events;
        prev_en = 0; prev_valid = 0; prev_ready = 0; prev_abort = 0;
        clr_len = 0; run_idx = 0;
        continue;
      end
      if (prev_valid && !prev_ready && !prev_abort) begin
        chk("valid_hold", 32'(resp_valid), 32'(1));
        chk("resp_hold", 32'(response), 32'(prev_resp));
      end
      if (cnt_enable && !prev_en) begin
        chk("clear_len", 32'(clr_len), 32'(CLEAR_CYCLES));
        chk("mux_sel_order", 32'(mux_sel), 32'(run_idx));
        run_sel = mux_sel;
        run_idx++;
      end else if (cnt_enable) begin
        chk("mux_sel_stable", 32'(mux_sel), 32'(run_sel));
      end
      if (busy && !cnt_clear && !cnt_enable && !resp_valid)
        chk("capture_after_run", 32'(prev_en), 32'(1));
      if (busy && cnt_clear && !resp_valid) clr_len++;
      else clr_len = 0;
      if (!busy) run_idx = 0;
      if (resp_valid && !prev_valid) begin
        chk("valid_expected", 32'(exp_q.size() != 0), 32'(1));
        chk("runs_per_word", 32'(run_idx), 32'(RESP_BITS));
      end
      if (resp_valid && resp_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_word", 32'(response), 32'(0));
        end else begin
          e = exp_q.pop_front();
          chk("response", 32'(response), 32'(e.word));
          chk("tie_flag", 32'(tie_flag), 32'(e.tie));
        end
      end
      prev_en    = cnt_enable;
      prev_valid = resp_valid;
      prev_ready = resp_ready;
      prev_abort = abort;
      prev_resp  = response;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_cnt_clear"}, 32'(cnt_clear), 32'(1));
    chk({tag, "_cnt_enable"}, 32'(cnt_enable), 32'(0));
    chk({tag, "_busy"}, 32'(busy), 32'(0));
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'(0));
    chk({tag, "_mux_sel"}, 32'(mux_sel), 32'(0));
    chk({tag, "_response"}, 32'(response), 32'(0));
    chk({tag, "_tie_flag"}, 32'(tie_flag), 32'(0));
  endtask

  task automatic run_word(input int mode, input bit hold, input int ready_wait);
    bit ok = 0;
    fill(mode);
    hold_fin = hold;
    exp_q.push_back(model());
    pulse_start();
    for (int c = 0; c < 4000; c++) begin
      if (resp_valid) begin ok = 1; break; end
      tick();
    end
    if (!ok) begin
      chk("valid_timeout", 32'(0), 32'(1));
      hold_fin = 1'b0;
      return;
    end
    for (int c = 0; c < ready_wait; c++) begin
      start = (c % 5 == 2);
      tick();
    end
    start = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("post_xfer_valid", 32'(resp_valid), 32'(0));
    chk("post_xfer_busy", 32'(busy), 32'(0));
    hold_fin = 1'b0;
    repeat (2) tick();
  endtask

  task automatic wait_for(input int kind, input int sel, output bit ok);
    ok = 0;
    for (int c = 0; c < 4000; c++) begin
      if (kind == 0 && cnt_enable && mux_sel == SEL_W'(sel)) begin ok = 1; break; end
      if (kind == 1 && busy && !cnt_clear && !cnt_enable && !resp_valid && mux_sel == SEL_W'(sel)) begin
        ok = 1; break;
      end
      tick();
    end
    if (!ok) chk("wait_timeout", 32'(0), 32'(1));
  endtask

  initial begin
    bit ok;
    reset = 1'b1; start = 1'b0; abort = 1'b0; resp_ready = 1'b0; finished = 1'b0;
    count_a = '0; count_b = '0;
    for (int i = 0; i < RESP_BITS; i++) begin ta[i] = '0; tbv[i] = '0; end
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("rst");
    reset = 1'b0;
    tick();

    fin_delay = 10;
    run_word(0, 1'b0, 0);
    run_word(1, 1'b0, 3);
    run_word(2, 1'b0, 0);
    run_word(3, 1'b0, 20);
    run_word(1, 1'b1, 0);

    // abort mid-RUN of challenge 7; nothing queued, so a stray valid is caught
    fill(3);
    pulse_start();
    wait_for(0, 7, ok);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", 32'(busy), 32'(0));
    chk("abort_valid", 32'(resp_valid), 32'(0));
    chk("abort_enable", 32'(cnt_enable), 32'(0));
    chk("abort_clear", 32'(cnt_clear), 32'(1));
    chk("abort_mux_sel", 32'(mux_sel), 32'(0));
    repeat (5) tick();
    run_word(3, 1'b0, 1);

    // async reset landing mid-cycle while in CAPTURE of challenge 5
    fill(3);
    pulse_start();
    wait_for(1, 5, ok);
    #1 reset = 1'b1;
    #1 check_reset_values("async_rst");
    #1 reset = 1'b0;
    rst_events++;
    repeat (3) tick();
    run_word(2, 1'b0, 0);

    // start and abort together in IDLE: abort wins
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk("start_abort_busy", 32'(busy), 32'(0));

    for (int r = 0; r < 4; r++) begin
      fin_delay = $urandom_range(1, 12);
      run_word(3, bit'($urandom_range(0, 1)), $urandom_range(0, 4));
    end
    repeat (3) tick();
    chk("queue_drained", 32'(exp_q.size()), 32'(0));
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
